spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
Parametrised successor to the original free-running SPI receiver. It oversamples SPI on the system clock, so all logic is in one clock domain. It frames words with chip-select, supports all four SPI modes and either bit order, and buffers received words in a first-word-fall-through (FWFT) FIFO with a valid/ready output. It sits between the host SPI pins and the panel pixel/command path.

Parameters:
WORD_WIDTH, 16, bits per received word (2..32)
FIFO_DEPTH, 4, FIFO entries (power of two, 2..16)
CPOL, 0, idle level of spi_clk
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
MSB_FIRST, 1, 1 = first bit received lands in bit WORD_WIDTH-1; 0 = lands in bit 0

Ports:
clk  in  1  system clock, at least 4x spi_clk frequency
reset  in  1  asynchronous, active-low reset
spi_clk  in  1  SPI clock pin, asynchronous to clk
spi_mosi  in  1  SPI data pin, asynchronous
spi_cs_n  in  1  SPI chip-select pin, active-low, asynchronous
out_data  out  WORD_WIDTH  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid is also high
fifo_level  out  clog2(FIFO_DEPTH)+1  number of FIFO entries
overrun  out  1  sticky: a completed word was dropped because the FIFO was full
clear_overrun  in  1  synchronous clear for overrun
frame_error  out  1  one-cycle pulse: chip-select deasserted with a partial word

Behaviour:
- Reset (reset=0, asynchronous): clears synchronisers, shift register, bit counter, FIFO pointers and overrun.
  - Out of reset: out_valid=0, fifo_level=0, overrun=0, frame_error=0, out_data=0.
  - Synchronisers reset to spi_clk=CPOL, spi_cs_n=1.
- Synchronisation: each pin passes through a 2-flop synchroniser. A third register holds the previous synchronised spi_clk for edge detection.
- Sample edge: rising edge when CPOL==CPHA, otherwise falling edge. Edges are ignored while synchronised cs_n is 1.
- On each sample edge:
  - The synchronised mosi bit is shifted in, left shift if MSB_FIRST, right shift otherwise.
  - The bit counter increments.
  - When the count reaches WORD_WIDTH, the assembled word (including the current bit) is pushed to the FIFO in the same cycle and the counter wraps to 0. Back-to-back words need no cs_n toggle.
- Latency: out_valid rises 3 clk rising edges after the first clk edge that captures the final spi_clk pin transition, provided the FIFO was empty.
- cs_n deassertion (synchronised 0 to 1):
  - The counter clears and the partial word is discarded.
  - If the counter was nonzero, frame_error pulses high for exactly 1 cycle.
  - cs_n assertion also clears the counter.
- FIFO (FWFT):
  - out_data shows the head entry whenever out_valid=1; out_data is don't-care when empty.
  - A pop occurs when out_valid & out_ready.
  - Push while full: if a pop happens in the same cycle, the push is accepted and fifo_level is unchanged. With no pop, the word is dropped and overrun is set.
  - Push and pop in the same cycle while non-empty: fifo_level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun: stays high until a clear_overrun cycle. If set and clear occur in the same cycle, set wins.
- Reset mid-word: the partial word is lost with no frame_error, and the FIFO is emptied.
- No MISO path is provided; transmit is out of scope.

Test Plan:
- Mode 0, WORD_WIDTH=16, MSB first, clk = 8x spi_clk: send 0xA5C3 under cs_n=0 -> out_data=0xA5C3, out_valid=1, fifo_level=1. The valid rise lands within 3 clk cycles of the last synchronised edge.
- CPOL=1, CPHA=1, MSB_FIRST=0, WORD_WIDTH=8: send bits 1,0,0,0,0,0,0,0 -> out_data=0x01. Then send three more words without toggling cs_n -> 4 words, in order.
- FIFO_DEPTH=4, out_ready=0: send 0x0001..0x0005 -> fifo_level=4, overrun=1. Drain yields 0x0001..0x0004; 0x0005 is lost. Assert clear_overrun -> overrun=0.
- Send 7 bits of a 16-bit word, then raise cs_n -> frame_error is high for 1 cycle and no push occurs. The next full frame 0x1234 is received intact.
- FIFO full with out_ready=1 held: the next completed word arrives in the same cycle as a pop -> word accepted, fifo_level stays 4, overrun stays 0.
- Pull reset low after 9 bits with 2 words queued -> out_valid=0 and fifo_level=0 immediately. After release, 0xBEEF is received correctly.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_if
//   Bundles the SPI pins and the received-word stream of spi_slave_rx.
//
//   Signals:
//     spi_clk, spi_mosi, spi_cs_n : SPI pins from the host (asynchronous)
//     out_data                    : FIFO head word (WORD_WIDTH bits)
//     out_valid / out_ready       : valid/ready handshake on out_data
//     fifo_level                  : number of words held in the FIFO
//     overrun                     : sticky, a completed word was dropped
//     clear_overrun               : synchronous clear for overrun
//     frame_error                 : one-cycle pulse, cs_n rose mid-word
//
//   Modports:
//     slave  : receiver side (spi_slave_rx)
//     master : host-pin driver and word consumer (system / testbench)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_slave_rx_if #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  spi_clk;
    logic                  spi_mosi;
    logic                  spi_cs_n;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [LVL_W-1:0]      fifo_level;
    logic                  overrun;
    logic                  clear_overrun;
    logic                  frame_error;

    modport slave (
        input  spi_clk, spi_mosi, spi_cs_n, out_ready, clear_overrun,
        output out_data, out_valid, fifo_level, overrun, frame_error
    );

    modport master (
        output spi_clk, spi_mosi, spi_cs_n, out_ready, clear_overrun,
        input  out_data, out_valid, fifo_level, overrun, frame_error
    );
endinterface

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
//   Oversampling SPI receiver. The SPI pins are synchronised into the system
//   clock domain, sample edges are detected on the synchronised spi_clk, and
//   completed words are buffered in a first-word-fall-through FIFO with a
//   valid/ready output. Supports all four SPI modes and either bit order.
//
//   Parameters:
//     WORD_WIDTH : bits per received word (2..32)
//     FIFO_DEPTH : FIFO entries (power of two, 2..16)
//     CPOL       : idle level of spi_clk
//     CPHA       : 0 = sample on leading edge, 1 = sample on trailing edge
//     MSB_FIRST  : 1 = first bit lands in the MSB, 0 = first bit lands in bit 0
//
//   Ports:
//     clk   : system clock, at least 4x the spi_clk frequency
//     reset : asynchronous, active-low reset
//     bus   : spi_slave_rx_if.slave (SPI pins, word stream, status)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_slave_rx #(
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    spi_slave_rx_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WORD_WIDTH);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    localparam bit SAMPLE_RISING = (CPOL == CPHA);

    // Synchroniser chains and previous-value registers for edge detection
    logic r_clkSync1, r_clkSync2, r_clkPrev;
    logic r_mosiSync1, r_mosiSync2;
    logic r_csSync1, r_csSync2, r_csPrev;

    // Registered events: one stage after detection
    logic r_sampleStb;
    logic r_sampleBit;
    logic r_csRiseStb;
    logic r_csFallStb;

    // Word assembly
    logic [WORD_WIDTH-1:0] r_shiftReg;
    logic [CNT_W-1:0]      r_bitCnt;
    logic                  r_frameErr;

    // FIFO state
    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overrun;

    logic                  w_clkRise;
    logic                  w_clkFall;
    logic                  w_sampleEdge;
    logic                  w_csRise;
    logic                  w_csFall;
    logic [WORD_WIDTH-1:0] w_nextWord;
    logic                  w_wordDone;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_pushOk;
    logic                  w_drop;

    // Two-flop synchronisers on every pin, plus one more register on spi_clk
    // and cs_n holding the previous synchronised value. The reset values
    // match an idle bus so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clkSync1  <= CPOL;
            r_clkSync2  <= CPOL;
            r_clkPrev   <= CPOL;
            r_mosiSync1 <= 1'b0;
            r_mosiSync2 <= 1'b0;
            r_csSync1   <= 1'b1;
            r_csSync2   <= 1'b1;
            r_csPrev    <= 1'b1;
        end else begin
            r_clkSync1  <= bus.spi_clk;
            r_clkSync2  <= r_clkSync1;
            r_clkPrev   <= r_clkSync2;
            r_mosiSync1 <= bus.spi_mosi;
            r_mosiSync2 <= r_mosiSync1;
            r_csSync1   <= bus.spi_cs_n;
            r_csSync2   <= r_csSync1;
            r_csPrev    <= r_csSync2;
        end
    end

    assign w_clkRise    = r_clkSync2 & ~r_clkPrev;
    assign w_clkFall    = ~r_clkSync2 & r_clkPrev;
    assign w_sampleEdge = (SAMPLE_RISING ? w_clkRise : w_clkFall) & ~r_csSync2;
    assign w_csRise     = r_csSync2 & ~r_csPrev;
    assign w_csFall     = ~r_csSync2 & r_csPrev;

    // Detected events are registered once together with the data bit. Sample
    // strobes and cs_n edges travel through the same stage so they are always
    // handled in the order they happened on the pins; a sample strobe can
    // never coincide with a cs_n edge because sampling is gated by cs_n.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sampleStb <= 1'b0;
            r_sampleBit <= 1'b0;
            r_csRiseStb <= 1'b0;
            r_csFallStb <= 1'b0;
        end else begin
            r_sampleStb <= w_sampleEdge;
            r_sampleBit <= r_mosiSync2;
            r_csRiseStb <= w_csRise;
            r_csFallStb <= w_csFall;
        end
    end

    // Word being assembled including the current bit; this is also what gets
    // pushed when the final bit of a word arrives.
    assign w_nextWord = MSB_FIRST ? {r_shiftReg[WORD_WIDTH-2:0], r_sampleBit}
                                  : {r_sampleBit, r_shiftReg[WORD_WIDTH-1:1]};
    assign w_wordDone = r_sampleStb & (r_bitCnt == LAST_BIT);

    // Shift register and bit counter. Any cs_n edge restarts framing; the
    // counter wraps on its own after a full word so back-to-back words need
    // no cs_n toggle. A cs_n rise with bits pending raises frame_error for
    // one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_frameErr <= r_csRiseStb & (r_bitCnt != '0);
            if (r_csRiseStb || r_csFallStb) begin
                r_bitCnt <= '0;
            end else if (r_sampleStb) begin
                r_shiftReg <= w_nextWord;
                r_bitCnt   <= w_wordDone ? '0 : r_bitCnt + 1'b1;
            end
        end
    end

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == FULL_LVL);
    assign w_pop    = ~w_empty & bus.out_ready;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign w_pushOk = w_wordDone & (~w_full | w_pop);
    assign w_drop   = w_wordDone & w_full & ~w_pop;

    // FIFO storage needs no reset: an entry is only ever read after being
    // written, and out_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= w_nextWord;
        end
    end

    // FIFO pointers, fill level and sticky overrun. Pointers are exactly
    // log2(depth) bits wide so they wrap naturally. When overrun is set and
    // cleared in the same cycle the new drop wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.out_data    = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.out_valid   = ~w_empty;
    assign bus.fifo_level  = r_level;
    assign bus.overrun     = r_overrun;
    assign bus.frame_error = r_frameErr;

endmodule

// File: tb/tb_spi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx
//   Two receivers share clk/reset: busA/dutA is mode 0, 16-bit, MSB first;
//   busB/dutB is mode 3, 8-bit, LSB first. System clock is 8x spi_clk.
//   Expected words are queued when a frame is driven and popped as the FIFO
//   is drained.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset;

    // 100 MHz system clock
    always #5 clk = ~clk;

    spi_slave_rx_if #(.WORD_WIDTH(16), .FIFO_DEPTH(4)) busA ();
    spi_slave_rx_if #(.WORD_WIDTH(8),  .FIFO_DEPTH(4)) busB ();

    spi_slave_rx #(
        .WORD_WIDTH(16), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)
    ) dutA (
        .clk(clk), .reset(reset), .bus(busA)
    );

    spi_slave_rx #(
        .WORD_WIDTH(8), .FIFO_DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)
    ) dutB (
        .clk(clk), .reset(reset), .bus(busB)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] expA[$];
    logic [7:0]  expB[$];

    time lastSampleA = 0;
    time lastSampleB = 0;
    time validRiseA  = 0;
    int  bitsSentA   = 0;
    int  feA         = 0;
    int  feB         = 0;

    // Time of each out_valid rise on bus A, for the latency check
    always @(posedge busA.out_valid) validRiseA = $time;

    // Number of clk cycles frame_error was seen high
    always @(negedge clk) begin
        if (busA.frame_error === 1'b1) feA++;
        if (busB.frame_error === 1'b1) feB++;
    end

    // Global watchdog so the bench can never hang
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: time limit reached, got no summary, expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setPins(input int sel, input logic c, input logic m);
        if (sel == 0) begin
            busA.spi_clk  = c;
            busA.spi_mosi = m;
        end else begin
            busB.spi_clk  = c;
            busB.spi_mosi = m;
        end
    endtask

    task automatic setCs(input int sel, input logic v);
        if (sel == 0) busA.spi_cs_n = v;
        else          busB.spi_cs_n = v;
    endtask

    // Drives nbits of word on the selected bus: bus A in mode 0 MSB first,
    // bus B in mode 3 LSB first. Leaves spi_clk at its idle level.
    task automatic applyStimulus(input int sel, input logic [31:0] word, input int nbits);
        int   idx;
        logic b;
        for (int i = 0; i < nbits; i++) begin
            idx = (sel == 0) ? nbits - 1 - i : i;
            b   = word[idx];
            if (sel == 0) begin
                setPins(0, 1'b0, b);
                #HALF;
                setPins(0, 1'b1, b);
                lastSampleA = $time;
                bitsSentA++;
                #HALF;
                setPins(0, 1'b0, b);
            end else begin
                setPins(1, 1'b0, b);
                #HALF;
                setPins(1, 1'b1, b);
                lastSampleB = $time;
                #HALF;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        busA.spi_clk = 1'b0; busA.spi_mosi = 1'b0; busA.spi_cs_n = 1'b1;
        busA.out_ready = 1'b0; busA.clear_overrun = 1'b0;
        busB.spi_clk = 1'b1; busB.spi_mosi = 1'b0; busB.spi_cs_n = 1'b1;
        busB.out_ready = 1'b0; busB.clear_overrun = 1'b0;
        @(negedge clk);
        checkCount++;
        if (busA.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", busA.out_valid);
        else passCount++;
        checkCount++;
        if (busA.fifo_level !== 3'd0) $display("[TB] FAIL reset_level: got %0d expected 0", busA.fifo_level);
        else passCount++;
        checkCount++;
        if (busA.overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", busA.overrun);
        else passCount++;
        checkCount++;
        if (busA.frame_error !== 1'b0) $display("[TB] FAIL reset_frame_error: got %b expected 0", busA.frame_error);
        else passCount++;
        checkCount++;
        if (busA.out_data !== 16'h0000) $display("[TB] FAIL reset_data: got %h expected 0000", busA.out_data);
        else passCount++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (busA.out_valid !== 1'b0 || busA.fifo_level !== 3'd0)
            $display("[TB] FAIL post_reset_A: got valid=%b level=%0d expected valid=0 level=0", busA.out_valid, busA.fifo_level);
        else passCount++;
        checkCount++;
        if (busB.out_valid !== 1'b0 || busB.out_data !== 8'h00)
            $display("[TB] FAIL post_reset_B: got valid=%b data=%h expected valid=0 data=00", busB.out_valid, busB.out_data);
        else passCount++;
    endtask

    task automatic test_mode0_word();
        logic [15:0] e;
        setCs(0, 1'b0);
        #HALF;
        applyStimulus(0, 32'hA5C3, 16);
        expA.push_back(16'hA5C3);
        #HALF;
        setCs(0, 1'b1);
        repeat (4) @(negedge clk);
        checkCount++;
        if (validRiseA - lastSampleA !== 35)
            $display("[TB] FAIL mode0_latency: got %0t ns after last edge expected 35", validRiseA - lastSampleA);
        else passCount++;
        checkCount++;
        if (busA.fifo_level !== 3'd1) $display("[TB] FAIL mode0_level: got %0d expected 1", busA.fifo_level);
        else passCount++;
        while (expA.size() > 0) begin
            e = expA.pop_front();
            for (int t = 0; t < 200 && busA.out_valid !== 1'b1; t++) @(negedge clk);
            checkCount++;
            if (busA.out_valid !== 1'b1 || busA.out_data !== e)
                $display("[TB] FAIL mode0_data: got valid=%b data=%h expected valid=1 data=%h", busA.out_valid, busA.out_data, e);
            else passCount++;
            busA.out_ready = 1'b1;
            @(negedge clk);
            busA.out_ready = 1'b0;
        end
        checkCount++;
        if (busA.out_valid !== 1'b0 || busA.fifo_level !== 3'd0 || feA !== 0)
            $display("[TB] FAIL mode0_drained: got valid=%b level=%0d fe=%0d expected 0/0/0", busA.out_valid, busA.fifo_level, feA);
        else passCount++;
    endtask

    task automatic test_mode3_lsb();
        logic [7:0] words [4];
        logic [7:0] e;
        words = '{8'h01, 8'h5A, 8'hC3, 8'h80};
        setCs(1, 1'b0);
        #HALF;
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1, 32'(words[w]), 8);
            expB.push_back(words[w]);
        end
        #HALF;
        setCs(1, 1'b1);
        repeat (6) @(negedge clk);
        checkCount++;
        if (busB.fifo_level !== 3'd4 || busB.overrun !== 1'b0 || feB !== 0)
            $display("[TB] FAIL mode3_status: got level=%0d ovr=%b fe=%0d expected 4/0/0", busB.fifo_level, busB.overrun, feB);
        else passCount++;
        while (expB.size() > 0) begin
            e = expB.pop_front();
            for (int t = 0; t < 200 && busB.out_valid !== 1'b1; t++) @(negedge clk);
            checkCount++;
            if (busB.out_valid !== 1'b1 || busB.out_data !== e)
                $display("[TB] FAIL mode3_data: got valid=%b data=%h expected valid=1 data=%h", busB.out_valid, busB.out_data, e);
            else passCount++;
            busB.out_ready = 1'b1;
            @(negedge clk);
            busB.out_ready = 1'b0;
        end
        checkCount++;
        if (busB.out_valid !== 1'b0) $display("[TB] FAIL mode3_drained: got valid=%b expected 0", busB.out_valid);
        else passCount++;
    endtask

    task automatic test_overrun();
        logic [15:0] e;
        logic        expOvr;
        expOvr = 1'b0;
        busA.out_ready = 1'b0;
        setCs(0, 1'b0);
        #HALF;
        for (int v = 1; v <= 5; v++) begin
            applyStimulus(0, 32'(v), 16);
            if (expA.size() < 4) expA.push_back(16'(v));
            else                 expOvr = 1'b1;
        end
        #HALF;
        setCs(0, 1'b1);
        repeat (4) @(negedge clk);
        checkCount++;
        if (busA.fifo_level !== 3'd4) $display("[TB] FAIL overrun_level: got %0d expected 4", busA.fifo_level);
        else passCount++;
        checkCount++;
        if (busA.overrun !== expOvr) $display("[TB] FAIL overrun_flag: got %b expected %b", busA.overrun, expOvr);
        else passCount++;
        while (expA.size() > 0) begin
            e = expA.pop_front();
            for (int t = 0; t < 200 && busA.out_valid !== 1'b1; t++) @(negedge clk);
            checkCount++;
            if (busA.out_valid !== 1'b1 || busA.out_data !== e)
                $display("[TB] FAIL overrun_drain: got valid=%b data=%h expected valid=1 data=%h", busA.out_valid, busA.out_data, e);
            else passCount++;
            busA.out_ready = 1'b1;
            @(negedge clk);
            busA.out_ready = 1'b0;
        end
        checkCount++;
        if (busA.out_valid !== 1'b0 || busA.overrun !== 1'b1)
            $display("[TB] FAIL overrun_sticky: got valid=%b ovr=%b expected valid=0 ovr=1", busA.out_valid, busA.overrun);
        else passCount++;
        busA.clear_overrun = 1'b1;
        @(negedge clk);
        busA.clear_overrun = 1'b0;
        checkCount++;
        if (busA.overrun !== 1'b0) $display("[TB] FAIL overrun_clear: got %b expected 0", busA.overrun);
        else passCount++;
    endtask

    task automatic test_frame_error();
        logic [15:0] e;
        feA = 0;
        setCs(0, 1'b0);
        #HALF;
        applyStimulus(0, 32'h5B, 7);
        #HALF;
        setCs(0, 1'b1);
        repeat (8) @(negedge clk);
        checkCount++;
        if (feA !== 1) $display("[TB] FAIL frame_error_pulse: got %0d cycles expected 1", feA);
        else passCount++;
        checkCount++;
        if (busA.fifo_level !== 3'd0 || busA.out_valid !== 1'b0)
            $display("[TB] FAIL frame_error_nopush: got level=%0d valid=%b expected 0/0", busA.fifo_level, busA.out_valid);
        else passCount++;
        setCs(0, 1'b0);
        #HALF;
        applyStimulus(0, 32'h1234, 16);
        expA.push_back(16'h1234);
        #HALF;
        setCs(0, 1'b1);
        repeat (6) @(negedge clk);
        checkCount++;
        if (busA.fifo_level !== 3'd1 || feA !== 1)
            $display("[TB] FAIL frame_after_error: got level=%0d fe=%0d expected 1/1", busA.fifo_level, feA);
        else passCount++;
        while (expA.size() > 0) begin
            e = expA.pop_front();
            for (int t = 0; t < 200 && busA.out_valid !== 1'b1; t++) @(negedge clk);
            checkCount++;
            if (busA.out_valid !== 1'b1 || busA.out_data !== e)
                $display("[TB] FAIL frame_recovery_data: got valid=%b data=%h expected valid=1 data=%h", busA.out_valid, busA.out_data, e);
            else passCount++;
            busA.out_ready = 1'b1;
            @(negedge clk);
            busA.out_ready = 1'b0;
        end
    endtask

    task automatic test_full_pop();
        logic [15:0] e;
        int          target;
        time         waitFor;
        busA.out_ready = 1'b0;
        setCs(0, 1'b0);
        #HALF;
        for (int v = 1; v <= 4; v++) begin
            applyStimulus(0, 32'(16'h1111 * v), 16);
            expA.push_back(16'(16'h1111 * v));
        end
        target = bitsSentA + 16;
        fork
            applyStimulus(0, 32'h5555, 16);
            begin
                for (int t = 0; t < 2000 && bitsSentA < target; t++) @(negedge clk);
                checkCount++;
                if (bitsSentA < target) begin
                    $display("[TB] FAIL full_pop_timeout: got %0d bits expected %0d", bitsSentA, target);
                end else begin
                    passCount++;
                    waitFor = lastSampleA + 30;
                    if (waitFor > $time) #(waitFor - $time);
                    e = expA.pop_front();
                    checkCount++;
                    if (busA.fifo_level !== 3'd4 || busA.out_data !== e)
                        $display("[TB] FAIL full_pop_head: got level=%0d data=%h expected 4/%h", busA.fifo_level, busA.out_data, e);
                    else passCount++;
                    busA.out_ready = 1'b1;
                    expA.push_back(16'h5555);
                    #10;
                    busA.out_ready = 1'b0;
                    checkCount++;
                    if (busA.fifo_level !== 3'd4 || busA.overrun !== 1'b0)
                        $display("[TB] FAIL full_pop_accept: got level=%0d ovr=%b expected 4/0", busA.fifo_level, busA.overrun);
                    else passCount++;
                end
            end
        join
        #HALF;
        setCs(0, 1'b1);
        repeat (4) @(negedge clk);
        while (expA.size() > 0) begin
            e = expA.pop_front();
            for (int t = 0; t < 200 && busA.out_valid !== 1'b1; t++) @(negedge clk);
            checkCount++;
            if (busA.out_valid !== 1'b1 || busA.out_data !== e)
                $display("[TB] FAIL full_pop_drain: got valid=%b data=%h expected valid=1 data=%h", busA.out_valid, busA.out_data, e);
            else passCount++;
            busA.out_ready = 1'b1;
            @(negedge clk);
            busA.out_ready = 1'b0;
        end
        checkCount++;
        if (busA.out_valid !== 1'b0) $display("[TB] FAIL full_pop_empty: got valid=%b expected 0", busA.out_valid);
        else passCount++;
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] e;
        feA = 0;
        busA.out_ready = 1'b0;
        setCs(0, 1'b0);
        #HALF;
        applyStimulus(0, 32'h0A0A, 16);
        expA.push_back(16'h0A0A);
        applyStimulus(0, 32'h0B0B, 16);
        expA.push_back(16'h0B0B);
        applyStimulus(0, 32'h1A5, 9);
        repeat (4) @(negedge clk);
        checkCount++;
        if (busA.fifo_level !== 3'd2) $display("[TB] FAIL reset_mid_prelevel: got %0d expected 2", busA.fifo_level);
        else passCount++;
        reset = 1'b0;
        #1;
        expA.delete();
        checkCount++;
        if (busA.out_valid !== 1'b0 || busA.fifo_level !== 3'd0)
            $display("[TB] FAIL reset_mid_async: got valid=%b level=%0d expected 0/0", busA.out_valid, busA.fifo_level);
        else passCount++;
        setCs(0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkCount++;
        if (feA !== 0 || busA.overrun !== 1'b0)
            $display("[TB] FAIL reset_mid_flags: got fe=%0d ovr=%b expected 0/0", feA, busA.overrun);
        else passCount++;
        setCs(0, 1'b0);
        #HALF;
        applyStimulus(0, 32'hBEEF, 16);
        expA.push_back(16'hBEEF);
        #HALF;
        setCs(0, 1'b1);
        repeat (4) @(negedge clk);
        checkCount++;
        if (busA.fifo_level !== 3'd1) $display("[TB] FAIL reset_mid_level: got %0d expected 1", busA.fifo_level);
        else passCount++;
        while (expA.size() > 0) begin
            e = expA.pop_front();
            for (int t = 0; t < 200 && busA.out_valid !== 1'b1; t++) @(negedge clk);
            checkCount++;
            if (busA.out_valid !== 1'b1 || busA.out_data !== e)
                $display("[TB] FAIL reset_mid_data: got valid=%b data=%h expected valid=1 data=%h", busA.out_valid, busA.out_data, e);
            else passCount++;
            busA.out_ready = 1'b1;
            @(negedge clk);
            busA.out_ready = 1'b0;
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_mode0_word();
        test_mode3_lsb();
        test_overrun();
        test_frame_error();
        test_full_pop();
        test_reset_mid_word();
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
